store_data_fwd: RTL

- Parametrised successor to the single-bit memory-data forwarding mux that sits between the EX/MEM pipeline register and data memory.
- Holds a DEPTH-entry history of recent register writebacks (loads and ALU results), each tagged with its destination register.
- For a store in MEM, picks the newest matching writeback as store data, otherwise the register-file value.
- Covers lw->sw back-to-back and lw->x->sw distances without stalling.

---
 rtl/mips_fwd_pkg.sv | 23 ++
 rtl/fwd_hist_entry.sv | 43 ++++
 rtl/store_data_fwd.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_fwd_pkg.sv
// Shared types and helpers for the store-data forwarding slice.
package mips_fwd_pkg;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned FWD_DWIDTH = 32;
  localparam int unsigned FWD_AWIDTH = 5;

  typedef struct packed {
    logic                  valid;
    logic [FWD_AWIDTH-1:0] rd;
    logic [FWD_DWIDTH-1:0] data;
  } fwd_entry_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fwd_hist_entry.sv
// One writeback history slot: async reset, clear/load controls, tag match.
module fwd_hist_entry #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_valid,
  input  logic [AWIDTH-1:0] i_rd,
  input  logic [DWIDTH-1:0] i_data,
  input  logic [AWIDTH-1:0] i_rt,
  output logic              o_valid,
  output logic [AWIDTH-1:0] o_rd,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_match
);

  logic              r_valid;
  logic [AWIDTH-1:0] r_rd;
  logic [DWIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_rd    <= i_rd;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_rd    = r_rd;
  assign o_data  = r_data;
  assign o_match = r_valid && (r_rd == i_rt);

endmodule

// File: rtl/store_data_fwd.sv
// Store-data forwarding: DEPTH-entry writeback history plus live bypass.
// Optional FWD_STATS_EN adds fwd_count / fwd_live forwarding counters.
module store_data_fwd
  import mips_fwd_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           flush,
  input  logic                           wb_valid,
  input  logic [AWIDTH-1:0]              wb_rd,
  input  logic [DWIDTH-1:0]              wb_data,
  input  logic                           st_valid,
  input  logic [AWIDTH-1:0]              st_rt,
  input  logic [DWIDTH-1:0]              regdata,
  output logic [DWIDTH-1:0]              out,
  output logic                           fwd_hit,
  output logic [clog2(DEPTH+1)-1:0]      fwd_src
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                    fwd_count,
  output logic [31:0]                    fwd_live
`endif
);

  localparam int unsigned SRCW = clog2(DEPTH + 1);

  logic              w_wb_rec;
  logic              w_lookup;
  logic              w_valid    [DEPTH];
  logic [AWIDTH-1:0] w_rd       [DEPTH];
  logic [DWIDTH-1:0] w_data     [DEPTH];
  logic              w_match    [DEPTH];
  logic              w_in_valid [DEPTH];
  logic [AWIDTH-1:0] w_in_rd    [DEPTH];
  logic [DWIDTH-1:0] w_in_data  [DEPTH];

  assign w_wb_rec = wb_valid && (wb_rd != AWIDTH'(REG_ZERO));
  assign w_lookup = st_valid && (st_rt != AWIDTH'(REG_ZERO));

  // Entry 0 loads an invalid slot when no qualifying write, so age tracks pipeline distance.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hist
    if (g == 0) begin : g_head
      assign w_in_valid[g] = w_wb_rec;
      assign w_in_rd[g]    = wb_rd;
      assign w_in_data[g]  = wb_data;
    end else begin : g_tail
      assign w_in_valid[g] = w_valid[g-1];
      assign w_in_rd[g]    = w_rd[g-1];
      assign w_in_data[g]  = w_data[g-1];
    end

    fwd_hist_entry #(
      .DWIDTH(DWIDTH),
      .AWIDTH(AWIDTH)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .i_clear (flush),
      .i_load  (!stall),
      .i_valid (w_in_valid[g]),
      .i_rd    (w_in_rd[g]),
      .i_data  (w_in_data[g]),
      .i_rt    (st_rt),
      .o_valid (w_valid[g]),
      .o_rd    (w_rd[g]),
      .o_data  (w_data[g]),
      .o_match (w_match[g])
    );
  end

  // Scan oldest to newest so the newest match overrides; live bypass beats all.
  always_comb begin
    out     = regdata;
    fwd_hit = 1'b0;
    fwd_src = '0;
    if (w_lookup) begin
      for (int unsigned k = DEPTH; k > 0; k--) begin
        if (w_match[k-1]) begin
          out     = w_data[k-1];
          fwd_hit = 1'b1;
          fwd_src = SRCW'(k);
        end
      end
      if (wb_valid && (wb_rd == st_rt)) begin
        out     = wb_data;
        fwd_hit = 1'b1;
        fwd_src = '0;
      end
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] r_fwd_count;
  logic [31:0] r_fwd_live;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_count <= '0;
      r_fwd_live  <= '0;
    end else if (st_valid && fwd_hit && !stall) begin
      r_fwd_count <= r_fwd_count + 32'd1;
      if (fwd_src == '0) r_fwd_live <= r_fwd_live + 32'd1;
    end
  end

  assign fwd_count = r_fwd_count;
  assign fwd_live  = r_fwd_live;
`endif

endmodule
